fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register; directly upstream of the main control decoder.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 15 +
 rtl/fetch_stage_ifid_reg.sv | 73 +++++++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: the opcodes the control decoder cares about, the fetch
// increment and the fetch FSM state encoding.
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE  = 6'b000000;
  localparam logic [5:0]  OP_ADDI   = 6'b001000;
  localparam logic [5:0]  OP_BEQ    = 6'b000100;
  localparam logic [5:0]  OP_J      = 6'b000010;
  localparam logic [5:0]  OP_LW     = 6'b100011;
  localparam logic [5:0]  OP_SW     = 6'b101011;
  localparam logic [31:0] INSTR_NOP = 32'h0;
  localparam int          PC_INC    = 4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: one request strobe with address, one read-data return.
interface fetch_stage_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_rvalid, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_rvalid, imem_rdata);

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register plus a one-entry skid buffer that catches a returning
// word while decode is stalled.
module ifid_reg
  import mips_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               load_mem,
  input  logic               write_skid,
  input  logic               load_skid,
  input  logic [INSTR_W-1:0] rdata,
  input  logic [PC_W-1:0]    fetch_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [5:0]         ifid_opcode,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc4
);

  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  // NOTE: the data fields are reset too; ifid_instr=0 must be visible out of reset,
  // and a single skid entry costs nothing to clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_instr <= INSTR_NOP[INSTR_W-1:0];
      ifid_pc    <= '0;
      ifid_pc4   <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      ifid_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (load_mem) begin
        ifid_valid <= 1'b1;
        ifid_instr <= rdata;
        ifid_pc    <= fetch_pc;
        ifid_pc4   <= fetch_pc + PC_W'(PC_INC);
      end else if (load_skid) begin
        ifid_valid <= 1'b1;
        ifid_instr <= skid_instr;
        ifid_pc    <= skid_pc;
        ifid_pc4   <= skid_pc + PC_W'(PC_INC);
        skid_valid <= 1'b0;
      end else if (!stall) begin
        ifid_valid <= 1'b0;
      end
      if (write_skid) begin
        skid_valid <= 1'b1;
        skid_instr <= rdata;
        skid_pc    <= fetch_pc;
      end
    end
  end

  assign ifid_opcode = ifid_instr[31:26];

  always @(posedge clk) begin
    if (!rst && load_skid)
      assert (skid_valid) else $error("ifid_reg: skid drained while empty");
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, one-outstanding-request fetch FSM and redirect/kill
// handling, feeding the IF/ID register in ifid_reg.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [5:0]         ifid_opcode,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc4
);

  fetch_state_t    state, next_state;
  logic [PC_W-1:0] pc, next_pc;
  logic            kill, next_kill;
  logic            load_mem, write_skid, load_skid, flush;
  logic            free;

  assign free = !ifid_valid || !stall;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      kill  <= 1'b0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      kill  <= next_kill;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_kill  = kill;
    load_mem   = 1'b0;
    write_skid = 1'b0;
    load_skid  = 1'b0;
    flush      = 1'b0;
    if (redirect) begin
      flush   = 1'b1;
      next_pc = redirect_pc;
      if (state == ST_WAIT && !imem.imem_rvalid) begin
        next_state = ST_WAIT;
        next_kill  = 1'b1;
      end else begin
        next_state = ST_FETCH;
        next_kill  = 1'b0;
      end
    end else begin
      unique case (state)
        ST_FETCH: next_state = ST_WAIT;
        ST_WAIT: begin
          if (imem.imem_rvalid) begin
            if (kill) begin
              next_kill  = 1'b0;
              next_state = ST_FETCH;
            end else if (free) begin
              load_mem   = 1'b1;
              next_pc    = pc + PC_W'(PC_INC);
              next_state = ST_FETCH;
            end else begin
              write_skid = 1'b1;
              next_state = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            load_skid  = 1'b1;
            next_pc    = pc + PC_W'(PC_INC);
            next_state = ST_FETCH;
          end
        end
        default: next_state = ST_FETCH;
      endcase
    end
  end

  // A redirect in FETCH withholds the stale request so only one is ever in flight.
  assign imem.imem_req  = !rst && (state == ST_FETCH) && !redirect;
  assign imem.imem_addr = pc;

  ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ifid_reg (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .load_mem    (load_mem),
    .write_skid  (write_skid),
    .load_skid   (load_skid),
    .rdata       (imem.imem_rdata),
    .fetch_pc    (pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_opcode (ifid_opcode),
    .ifid_pc     (ifid_pc),
    .ifid_pc4    (ifid_pc4)
  );

  always @(posedge clk) begin
    if (!rst && imem.imem_rvalid)
      assert (state == ST_WAIT) else $warning("fetch_stage: imem_rvalid outside WAIT ignored");
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset/wrap sequences, then random
// stall/redirect/latency traffic checked against an in-order program-stream model.
module tb_fetch_stage;
  import mips_pkg::*;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
  logic [5:0]  ifid_opcode;
  int          checks = 0;
  int          errors = 0;

  fetch_stage_if #(.PC_W(32), .INSTR_W(32)) imem ();

  fetch_stage #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_opcode (ifid_opcode),
    .ifid_pc     (ifid_pc),
    .ifid_pc4    (ifid_pc4)
  );

  always #HALF clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        rvalid;
    logic [31:0] rd_addr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic s, logic r, logic [31:0] rp, logic rv, logic [31:0] ra,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ep);
    vec_t v;
    v.stall = s; v.redirect = r; v.rpc = rp; v.rvalid = rv; v.rd_addr = ra;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  // Program image: fixed words at 0x0/0x4, hashed words with real opcodes elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [5:0]  op;
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h8C09_0004;
    h = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    case (a[4:2])
      3'd0: op = OP_RTYPE;
      3'd1: op = OP_ADDI;
      3'd2: op = OP_BEQ;
      3'd3: op = OP_J;
      3'd4: op = OP_LW;
      default: op = OP_SW;
    endcase
    return {op, h[25:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_entry(input string name, input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc);
    check({name, " valid"},  32'(ifid_valid), 32'h1);
    check({name, " pc"},     ifid_pc, pc);
    check({name, " instr"},  ifid_instr, w);
    check({name, " opcode"}, {26'h0, ifid_opcode}, {26'h0, w[31:26]});
    check({name, " pc4"},    ifid_pc4, pc + 32'h4);
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rp,
                       input logic rv, input logic [31:0] ra);
    stall = s;
    redirect = r;
    redirect_pc = rp;
    imem.imem_rvalid = rv;
    imem.imem_rdata = rv ? mem_word(ra) : 32'hDEAD_BEEF;
  endtask

  // Leaves the bench at a falling edge with rst released and the DUT in its first cycle.
  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #(HALF * 2 * 20000);
    $display("FAIL watchdog: run exceeded its cycle budget");
    $fatal(1);
  end

  initial begin
    bit          have_pend, got, flushed;
    int          pend_at, consumed;
    logic [31:0] pend_addr, exp_pc;

    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;

    vecs[0]  = mk('0, '0, 32'h0,  '0, 32'h0,  '1, 32'h0,  '0, 32'h0);
    vecs[1]  = mk('0, '0, 32'h0,  '1, 32'h0,  '0, 32'h0,  '0, 32'h0);
    vecs[2]  = mk('0, '0, 32'h0,  '0, 32'h0,  '1, 32'h4,  '1, 32'h0);
    vecs[3]  = mk('0, '0, 32'h0,  '1, 32'h4,  '0, 32'h0,  '0, 32'h0);
    vecs[4]  = mk('1, '0, 32'h0,  '0, 32'h0,  '1, 32'h8,  '1, 32'h4);
    vecs[5]  = mk('1, '0, 32'h0,  '1, 32'h8,  '0, 32'h0,  '1, 32'h4);
    vecs[6]  = mk('1, '0, 32'h0,  '0, 32'h0,  '0, 32'h0,  '1, 32'h4);
    vecs[7]  = mk('0, '0, 32'h0,  '0, 32'h0,  '0, 32'h0,  '1, 32'h4);
    vecs[8]  = mk('0, '0, 32'h0,  '0, 32'h0,  '1, 32'hC,  '1, 32'h8);
    vecs[9]  = mk('0, '0, 32'h0,  '1, 32'hC,  '0, 32'h0,  '0, 32'h0);
    vecs[10] = mk('1, '0, 32'h0,  '0, 32'h0,  '1, 32'h10, '1, 32'hC);
    vecs[11] = mk('1, '1, 32'h40, '0, 32'h0,  '0, 32'h0,  '1, 32'hC);
    vecs[12] = mk('0, '0, 32'h0,  '1, 32'h10, '0, 32'h0,  '0, 32'h0);
    vecs[13] = mk('0, '0, 32'h0,  '0, 32'h0,  '1, 32'h40, '0, 32'h0);
    vecs[14] = mk('0, '0, 32'h0,  '1, 32'h40, '0, 32'h0,  '0, 32'h0);
    vecs[15] = mk('1, '0, 32'h0,  '0, 32'h0,  '1, 32'h44, '1, 32'h40);
    vecs[16] = mk('1, '1, 32'h80, '1, 32'h44, '0, 32'h0,  '1, 32'h40);
    vecs[17] = mk('0, '0, 32'h0,  '0, 32'h0,  '1, 32'h80, '0, 32'h0);
    vecs[18] = mk('0, '0, 32'h0,  '1, 32'h80, '0, 32'h0,  '0, 32'h0);
    vecs[19] = mk('1, '0, 32'h0,  '0, 32'h0,  '1, 32'h84, '1, 32'h80);

    do_reset();

    // Straight-line fetch, stall into the skid, redirect in WAIT and with rvalid+stall.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].rvalid, vecs[i].rd_addr);
      #1;
      check($sformatf("vec%0d req", i), 32'(imem.imem_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) check($sformatf("vec%0d addr", i), imem.imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) check_entry($sformatf("vec%0d", i), vecs[i].exp_pc);
      else check($sformatf("vec%0d valid", i), 32'(ifid_valid), 32'h0);
      @(negedge clk);
    end

    // Mid-cycle reset while WAIT holds an outstanding request and IF/ID is occupied.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_entry("pre-reset", 32'h80);
    #2;
    rst = 1'b1;
    #1;
    check("async rst valid", 32'(ifid_valid), 32'h0);
    check("async rst instr", ifid_instr, 32'h0);
    check("async rst pc",    ifid_pc, 32'h0);
    check("async rst pc4",   ifid_pc4, 32'h0);
    check("async rst req",   32'(imem.imem_req), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Late response for the pre-reset request lands in FETCH and must be ignored.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h84);
    #1;
    check("restart req",  32'(imem.imem_req), 32'h1);
    check("restart addr", imem.imem_addr, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    #1;
    check("late rvalid ignored", 32'(ifid_valid), 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_entry("restart entry", 32'h0);
    check("after restart addr", imem.imem_addr, 32'h4);

    // PC wrap: redirect to the last word, next fetch must be 0x0.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h4);
    #1;
    check("wrap flush valid", 32'(ifid_valid), 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("wrap req addr", imem.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_entry("wrap entry", 32'hFFFF_FFFC);
    check("wrap next addr", imem.imem_addr, 32'h0);
    @(negedge clk);

    // Random traffic: the decoder must see the program stream in order, restarting at each target.
    do_reset();
    have_pend = 1'b0;
    flushed   = 1'b0;
    consumed  = 0;
    pend_at   = 0;
    pend_addr = 32'h0;
    exp_pc    = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 29) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom_range(0, 1023) << 2);
      got = 1'b0;
      if (have_pend && pend_at == c) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = mem_word(pend_addr);
        have_pend = 1'b0;
        got = 1'b1;
      end else begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = $urandom;
      end
      #1;
      if (flushed) check("rnd flushed", 32'(ifid_valid), 32'h0);
      flushed = redirect;
      if (imem.imem_req) begin
        check("rnd one outstanding", 32'(have_pend || got), 32'h0);
        have_pend = 1'b1;
        pend_addr = imem.imem_addr;
        pend_at   = c + int'($urandom_range(1, 3));
      end
      if (ifid_valid && !stall && !redirect) begin
        check_entry("rnd consumed", exp_pc);
        exp_pc = exp_pc + 32'h4;
        consumed++;
      end
      if (redirect) exp_pc = redirect_pc;
      @(negedge clk);
    end
    check("rnd progress", 32'(consumed >= 200), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
